// File: rtl/reg_access_arbiter.sv
// reg_access_arbiter: round-robin arbiter giving two requesters (I2C slave, local host)
// one-access-per-3-cycle use of a single-port register RAM.
module reg_access_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              i_ck,
  input  logic              i_rstn,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_rw0,
  input  logic              i_rw1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_ram_csn,
  output logic              o_ram_rw,
  output logic [ADDR_W-1:0] o_ram_address,
  output logic [DATA_W-1:0] o_ram_data,
  input  logic [DATA_W-1:0] i_ram_data,
  output logic              o_busy
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  logic [1:0]        state_q, state_d;
  logic              ptr_q, gnt_q, gnt_d, any_req;
  logic              csn_q, rw_q, ack0_q, ack1_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q, rdata0_q, rdata1_q;
  assign any_req = i_req0 | i_req1;
  // Pointer port wins a tie; a lone requester wins regardless of the pointer.
  assign gnt_d   = (i_req0 & i_req1) ? ptr_q : i_req1;
  always_comb
    state_d = (state_q == IDLE)   ? (any_req ? ACCESS : IDLE) :
              (state_q == ACCESS) ? RESP : IDLE;
  always_ff @(posedge i_ck or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      gnt_q    <= 1'b0;
      csn_q    <= 1'b1;
      rw_q     <= 1'b1;
      addr_q   <= '0;
      data_q   <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      csn_q   <= state_d != ACCESS;
      ack0_q  <= (state_q == ACCESS) & ~gnt_q;
      ack1_q  <= (state_q == ACCESS) & gnt_q;
      if (state_q == IDLE && any_req) begin
        gnt_q  <= gnt_d;
        ptr_q  <= ~gnt_d;
        rw_q   <= gnt_d ? i_rw1 : i_rw0;
        addr_q <= gnt_d ? i_addr1 : i_addr0;
        data_q <= gnt_d ? i_wdata1 : i_wdata0;
      end
      // RAM drove read data on the falling edge inside ACCESS
      if (state_q == ACCESS && rw_q && !gnt_q) rdata0_q <= i_ram_data;
      if (state_q == ACCESS && rw_q && gnt_q) rdata1_q <= i_ram_data;
    end
  end
  assign o_ram_csn     = csn_q;
  assign o_ram_rw      = rw_q;
  assign o_ram_address = addr_q;
  assign o_ram_data    = data_q;
  assign o_ack0        = ack0_q;
  assign o_ack1        = ack1_q;
  assign o_rdata0      = rdata0_q;
  assign o_rdata1      = rdata1_q;
  assign o_busy        = state_q != IDLE;
endmodule

// File: tb/tb_reg_access_arbiter.sv
// tb_reg_access_arbiter: directed and random checks of reg_access_arbiter against a
// transaction-level timing model and a behavioural RAM.
module tb_reg_access_arbiter;
  logic       clk = 1'b0;
  logic       rstn;
  logic       req[2], rw[2];
  logic [3:0] addr[2];
  logic [7:0] wdata[2];
  logic       ack0, ack1, csn, ram_rw, busy;
  logic [7:0] rdata0, rdata1, ram_wdata, ram_rdata;
  logic [3:0] ram_addr;
  logic [7:0] ram_mem[16], ref_mem[16], exp_rd[2];
  int         n_chk = 0, n_fail = 0, k = 0, g = 0, gp = 0;
  bit         pend = 0, ptr = 0, rnd = 0, hold = 0, logging = 0;
  logic       grw;
  logic [3:0] gaddr;
  logic [7:0] gdata, saved;
  int         ack_log[$];

  reg_access_arbiter dut (
    .i_ck(clk), .i_rstn(rstn),
    .i_req0(req[0]), .i_req1(req[1]), .i_rw0(rw[0]), .i_rw1(rw[1]),
    .i_addr0(addr[0]), .i_addr1(addr[1]), .i_wdata0(wdata[0]), .i_wdata1(wdata[1]),
    .o_ack0(ack0), .o_ack1(ack1), .o_rdata0(rdata0), .o_rdata1(rdata1),
    .o_ram_csn(csn), .o_ram_rw(ram_rw), .o_ram_address(ram_addr), .o_ram_data(ram_wdata),
    .i_ram_data(ram_rdata), .o_busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!csn) begin
      if (ram_rw) ram_rdata <= ram_mem[ram_addr];
      else ram_mem[ram_addr] <= ram_wdata;
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    pend = 0;
    ptr = 0;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
  endtask

  // One clock: update the model from the sampled inputs, check outputs, drive the next inputs.
  task automatic step();
    bit in_acc, in_resp;
    @(posedge clk);
    k++;
    if (pend && k == g + 1) begin
      if (grw) exp_rd[gp] = ref_mem[gaddr];
      else ref_mem[gaddr] = gdata;
    end
    if ((!pend || k >= g + 3) && (req[0] || req[1])) begin
      gp = (req[0] && req[1]) ? int'(ptr) : (req[1] ? 1 : 0);
      ptr = (gp == 0);
      g = k;
      pend = 1;
      grw = rw[gp];
      gaddr = addr[gp];
      gdata = wdata[gp];
    end
    #1;
    in_acc = pend && k == g;
    in_resp = pend && k == g + 1;
    chk("csn", csn, !in_acc);
    chk("busy", busy, in_acc | in_resp);
    chk("ack0", ack0, in_resp && gp == 0);
    chk("ack1", ack1, in_resp && gp == 1);
    chk("ack_excl", ack0 & ack1, 0);
    chk("rdata0", rdata0, exp_rd[0]);
    chk("rdata1", rdata1, exp_rd[1]);
    if (in_acc) begin
      chk("ram_rw", ram_rw, grw);
      chk("ram_addr", ram_addr, gaddr);
      if (!grw) chk("ram_data", ram_wdata, gdata);
    end
    if (logging && ack0) ack_log.push_back(0);
    if (logging && ack1) ack_log.push_back(1);
    if (!hold && ack0) req[0] = 0;
    if (!hold && ack1) req[1] = 0;
    if (hold && ack_log.size() >= 6) begin
      req[0] = 0;
      req[1] = 0;
    end
    for (int p = 0; p < 2; p++)
      if (!req[p]) begin
        rw[p] = 1'($urandom);
        addr[p] = 4'($urandom);
        wdata[p] = 8'($urandom);
        if (rnd && $urandom_range(0, 2) == 0) req[p] = 1;
      end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((req[0] || req[1]) && n < 40) begin
      step();
      n++;
    end
    chk("timeout", {31'd0, req[0] | req[1]}, 0);
    req[0] = 0;
    req[1] = 0;
  endtask

  task automatic txn(input int p, input logic r, input logic [3:0] a, input logic [7:0] d);
    rw[p] = r;
    addr[p] = a;
    wdata[p] = d;
    req[p] = 1;
    wait_idle();
  endtask

  task automatic do_reset();
    req[0] = 0;
    req[1] = 0;
    rstn = 0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    rstn = 1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    ram_rdata = 8'h00;
    rw = '{1'b0, 1'b0};
    addr = '{4'd0, 4'd0};
    wdata = '{8'd0, 8'd0};
    do_reset();
    chk("rst_csn", csn, 1);
    chk("rst_rw", ram_rw, 1);
    chk("rst_busy", busy, 0);
    // Simultaneous requests from reset: port 0 first
    rw[0] = 1; addr[0] = 4'd1;
    rw[1] = 0; addr[1] = 4'd1; wdata[1] = 8'h3C;
    req[0] = 1; req[1] = 1;
    logging = 1;
    wait_idle();
    logging = 0;
    chk("both_order0", ack_log[0], 0);
    chk("both_order1", ack_log[1], 1);
    chk("both_rd0", rdata0, 8'h00);
    txn(0, 1, 4'd1, 8'h00);
    chk("reread_rd0", rdata0, 8'h3C);
    txn(0, 0, 4'd3, 8'hA5);
    txn(0, 1, 4'd3, 8'h00);
    chk("wr_rd_a5", rdata0, 8'hA5);
    saved = rdata0;
    txn(1, 0, 4'd15, 8'hFF);
    txn(1, 1, 4'd15, 8'h00);
    chk("p1_rd_ff", rdata1, 8'hFF);
    chk("p0_hold", rdata0, saved);
    // Continuous contention: strict alternation from a fresh pointer
    do_reset();
    ack_log.delete();
    rw[0] = 1; addr[0] = 4'd2;
    rw[1] = 0; addr[1] = 4'd4; wdata[1] = 8'h11;
    req[0] = 1; req[1] = 1;
    hold = 1; logging = 1;
    wait_idle();
    hold = 0; logging = 0;
    chk("alt_count", ack_log.size(), 6);
    foreach (ack_log[i]) chk("alt_seq", ack_log[i], i % 2);
    repeat (3) step();
    // Reset in the middle of a write's ACCESS cycle
    rw[0] = 0; addr[0] = 4'd5; wdata[0] = 8'h77; req[0] = 1;
    step();
    chk("pre_rst_csn", csn, 0);
    #1 rstn = 0;
    #1;
    chk("ar_csn", csn, 1);
    chk("ar_rw", ram_rw, 1);
    chk("ar_addr", ram_addr, 0);
    chk("ar_data", ram_wdata, 0);
    chk("ar_ack", {ack0, ack1}, 0);
    chk("ar_busy", busy, 0);
    chk("ar_rdata", {rdata0, rdata1}, 0);
    model_clear();
    req[0] = 0;
    #2 rstn = 1;
    repeat (3) step();
    txn(0, 1, 4'd5, 8'h00);
    chk("abort_no_wr", rdata0, 8'h00);
    // Random traffic against the model
    rnd = 1;
    repeat (600) step();
    rnd = 0;
    wait_idle();
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
